// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store port to a byte-addressed big-endian RAM; LSU_ALIGN_CHECK_EN adds a misalignment error.
module lsu_mem_port #(
  parameter int NUM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data_in,
  output logic [1:0]  mem_write_width,
  input  logic [63:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic we_q, sgn_q, err_q, accept, err, range_err;
  logic [1:0] size_q;
  logic [3:0] nbytes;
  logic [64:0] end_addr;
  logic [63:0] ld;
  function automatic logic [5:0] shamt(input logic [1:0] s);
    return s == 2'd0 ? 6'd0 : s == 2'd1 ? 6'd32 : s == 2'd2 ? 6'd48 : 6'd56;
  endfunction
  assign nbytes = 4'd8 >> req_size;
  assign end_addr = {1'b0, req_addr} + 65'(nbytes);
  assign range_err = end_addr > 65'(NUM_BYTES);
`ifdef LSU_ALIGN_CHECK_EN
  assign err = range_err | (|(req_addr[2:0] & 3'(nbytes - 4'd1)));
`else
  assign err = range_err;
`endif
  assign req_ready = (state == IDLE) && !rst;
  assign accept = req_valid && req_ready;
  assign resp_valid = state == RESP;
  assign mem_cs = accept && !err;
  assign mem_we = accept && req_we;
  assign mem_addr = accept ? req_addr : 64'd0;
  assign mem_data_in = accept ? req_wdata << shamt(req_size) : 64'd0;
  assign mem_write_width = accept ? req_size : 2'd0;
  // the addressed byte sits at the top, so right-justifying with an arithmetic shift sign-extends for free
  assign ld = sgn_q ? $unsigned($signed(mem_data_out) >>> shamt(size_q)) : mem_data_out >> shamt(size_q);
  // next-state logic
  always_comb begin
    next = state;
    next = state == IDLE ? (accept ? WAIT : IDLE) : state == WAIT ? RESP : (resp_ready ? IDLE : RESP);
  end
  // state, captured request fields and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      resp_data <= 64'd0;
      resp_err <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        we_q <= req_we;
        sgn_q <= req_signed;
        err_q <= err;
        size_q <= req_size;
      end
      if (state == WAIT) begin
        resp_data <= (err_q || we_q) ? 64'd0 : ld;
        resp_err <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed and random load/store checks against a byte-array reference model.
module tb_lsu_mem_port;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, req_signed = 0, resp_ready = 0;
  logic [1:0] req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, mem_cs, mem_we;
  logic [63:0] resp_data, mem_addr, mem_data_in, mem_data_out;
  logic [1:0] mem_write_width;
  int n_chk = 0, n_fail = 0;
  logic [63:0] last_data;
  logic last_err;
  bit [7:0] ram [4096];
  bit [7:0] ref_mem [4096];

  lsu_mem_port #(.NUM_BYTES(4096)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_write_width(mem_write_width), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // RAM: big-endian bytes, writes on the accept edge, one-cycle registered read
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int i = 0; i < (8 >> mem_write_width); i++)
          ram[int'(mem_addr) + i] <= mem_data_in[63 - 8*i -: 8];
      end else begin
        for (int i = 0; i < 8; i++)
          mem_data_out[63 - 8*i -: 8] <= (int'(mem_addr) + i < 4096) ? ram[int'(mem_addr) + i] : 8'h00;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [63:0] addr, input logic [1:0] size);
    logic [64:0] last;
    bit e;
    last = {1'b0, addr} + 65'(8 >> size);
    e = last > 65'd4096;
`ifdef LSU_ALIGN_CHECK_EN
    if (addr % (8 >> size) != 0) e = 1;
`endif
    return e;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [1:0] size, input bit sgn);
    int b;
    logic [63:0] v;
    b = 8 >> size;
    v = 0;
    for (int i = 0; i < b; i++) v = (v << 8) | 64'(ref_mem[int'(addr) + i]);
    if (sgn && b < 8 && v[8*b-1]) v = v | (~64'd0 << (8*b));
    return v;
  endfunction

  task automatic model_store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata);
    int b;
    b = 8 >> size;
    for (int i = 0; i < b; i++) ref_mem[int'(addr) + i] = wdata[8*(b-1-i) +: 8];
  endtask

  task automatic xact(input bit we, input logic [1:0] size, input bit sgn,
                      input logic [63:0] addr, input logic [63:0] wdata, input int bp);
    int b, lat;
    bit e;
    logic [63:0] exp_d;
    b = 8 >> size;
    e = model_err(addr, size);
    exp_d = (we || e) ? 64'd0 : model_load(addr, size, sgn);
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    #1;
    chk("accept_req_ready", req_ready, 1);
    chk("accept_mem_cs", mem_cs, !e);
    chk("accept_mem_addr", mem_addr, addr);
    chk("accept_mem_width", mem_write_width, size);
    if (!e) chk("accept_mem_we", mem_we, we);
    if (we) chk("accept_mem_data_in", mem_data_in, wdata << (64 - 8*b));
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("wait_mem_cs", mem_cs, 0);
    end while (!resp_valid && lat < 8);
    chk("latency", lat, 2);
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", resp_err, e);
    last_data = resp_data;
    last_err = resp_err;
    if (we && !e) model_store(addr, size, wdata);
    repeat (bp) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_data", resp_data, exp_d);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
    chk("post_req_ready", req_ready, 1);
    chk("post_resp_valid", resp_valid, 0);
  endtask

  initial begin
    logic [63:0] a, w;
    logic [1:0] s;
    req_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_we", mem_we, 0);
    req_valid = 0;
    rst = 0;

    xact(1, 2'd0, 0, 64'h10, 64'h0123456789ABCDEF, 0);
    xact(0, 2'd0, 0, 64'h10, 0, 0);
    chk("plan_load64", last_data, 64'h0123456789ABCDEF);
    xact(1, 2'd3, 0, 64'h13, 64'hFFFF_FFFF_FFFF_FF85, 0);
    xact(0, 2'd3, 1, 64'h13, 0, 0);
    chk("plan_lb_signed", last_data, 64'hFFFFFFFFFFFFFF85);
    xact(0, 2'd3, 0, 64'h13, 0, 0);
    chk("plan_lb_unsigned", last_data, 64'h85);
    xact(1, 2'd3, 0, 64'h12, 64'h7F, 0);
    xact(0, 2'd2, 1, 64'h12, 0, 0);
    chk("plan_lh_signed", last_data, 64'h7F85);
    xact(0, 2'd0, 0, 64'hFFC, 0, 0);
    chk("plan_range_err", last_err, 1);
    xact(0, 2'd3, 0, 64'hFFFFFFFFFFFFFFFF, 0, 0);
    chk("plan_wrap_err", last_err, 1);
    xact(0, 2'd3, 0, 64'hFFF, 0, 0);
    xact(0, 2'd1, 0, 64'hFFC, 0, 0);
    xact(0, 2'd0, 0, 64'h10, 0, 5);

    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd1; req_signed = 0; req_addr = 64'h40; req_wdata = 64'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_resp_valid", resp_valid, 0);
    chk("rst_wait_req_ready", req_ready, 0);
    rst = 0;
    model_store(64'h40, 2'd1, 64'hCAFEBABE);
    xact(0, 2'd1, 0, 64'h40, 0, 0);
    chk("plan_store_survives_rst", last_data, 64'hCAFEBABE);
    xact(0, 2'd1, 0, 64'h2, 0, 0);

    for (int n = 0; n < 60; n++) begin
      s = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 64'd4088 + 64'($urandom_range(0, 7));
        1: a = {$urandom, $urandom};
        default: a = 64'($urandom_range(0, 63));
      endcase
      w = {$urandom, $urandom};
      xact(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, w, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
